// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 16-bit address / 8-bit data memory port between
// the CPU and the sprite/OAM DMA requester. DMA has fixed priority.
// Build option ARB_STARVE_EN: adds a starvation guard that forces a CPU
// grant after STARVE consecutive DMA grants made while the CPU was waiting.
// Every access walks IDLE -> BUSY -> DONE, so throughput is one access per
// three cycles and the ack to the winner is a registered one-cycle pulse.
module mem_arbiter #(
  parameter int STARVE = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpureq,
  input  logic        cpuwr,
  input  logic [15:0] cpuaddr,
  input  logic [7:0]  cpuwdata,
  output logic [7:0]  cpurdata,
  output logic        cpuack,
  input  logic        dmareq,
  input  logic        dmawr,
  input  logic [15:0] dmaaddr,
  input  logic [7:0]  dmawdata,
  output logic [7:0]  dmardata,
  output logic        dmaack,
  output logic        memreq,
  output logic        memwr,
  output logic [15:0] memaddr,
  output logic [7:0]  memwdata,
  input  logic [7:0]  memrdata,
  input  logic        memack,
  output logic        owner,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  if (STARVE < 1 || STARVE > 15) begin : g_bad_starve
    $error("mem_arbiter: STARVE must be in 1..15");
  end

  state_t      r_state, w_next;
  logic        r_memreq, r_memwr, r_owner, r_cpuack, r_dmaack;
  logic [15:0] r_memaddr;
  logic [7:0]  r_memwdata, r_cpurdata, r_dmardata;
  logic        w_force_cpu, w_gnt_dma, w_gnt_cpu, w_grant;

`ifdef ARB_STARVE_EN
  localparam logic [3:0] STARVE_C = 4'(STARVE);
  logic [3:0] r_starve;

  assign w_force_cpu = cpureq && (r_starve >= STARVE_C);

  // Count DMA grants taken while the CPU waits; any CPU grant or idle CPU clears it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve <= 4'd0;
    end else if (r_state == S_IDLE) begin
      if (!cpureq || w_gnt_cpu)
        r_starve <= 4'd0;
      else if (w_gnt_dma && r_starve != 4'hF)
        r_starve <= r_starve + 4'd1;
    end
  end
`else
  assign w_force_cpu = 1'b0;
`endif

  // Grant decision only matters in IDLE; DMA wins unless the guard forces CPU
  assign w_gnt_dma = dmareq && !w_force_cpu;
  assign w_gnt_cpu = cpureq && !w_gnt_dma;
  assign w_grant   = (r_state == S_IDLE) && (w_gnt_dma || w_gnt_cpu);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next state: DONE always returns to IDLE without granting, so a held req
  // from the just-acked requester is not mistaken for a new one
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_grant) w_next = S_BUSY;
      S_BUSY:  if (memack)  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Memory-side request registers, read data capture and ack pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_memreq   <= 1'b0;
      r_memwr    <= 1'b0;
      r_memaddr  <= 16'h0000;
      r_memwdata <= 8'h00;
      r_owner    <= 1'b0;
      r_cpuack   <= 1'b0;
      r_dmaack   <= 1'b0;
      r_cpurdata <= 8'h00;
      r_dmardata <= 8'h00;
    end else begin
      r_cpuack <= 1'b0;
      r_dmaack <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_memreq   <= 1'b1;
            r_owner    <= w_gnt_dma;
            r_memwr    <= w_gnt_dma ? dmawr    : cpuwr;
            r_memaddr  <= w_gnt_dma ? dmaaddr  : cpuaddr;
            r_memwdata <= w_gnt_dma ? dmawdata : cpuwdata;
          end
        end
        S_BUSY: begin
          if (memack) begin
            r_memreq <= 1'b0;
            r_memwr  <= 1'b0;
            if (!r_memwr) begin
              if (r_owner) r_dmardata <= memrdata;
              else         r_cpurdata <= memrdata;
            end
            if (r_owner) r_dmaack <= 1'b1;
            else         r_cpuack <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign memreq   = r_memreq;
  assign memwr    = r_memwr;
  assign memaddr  = r_memaddr;
  assign memwdata = r_memwdata;
  assign owner    = r_owner;
  assign cpuack   = r_cpuack;
  assign dmaack   = r_dmaack;
  assign cpurdata = r_cpurdata;
  assign dmardata = r_dmardata;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of single accesses plus hand sequences for
// simultaneous requests, stuck-high memack, starvation and async reset.
module tb_mem_arbiter;

  logic        clk, reset_n;
  logic        cpureq, cpuwr, dmareq, dmawr, memack;
  logic [15:0] cpuaddr, dmaaddr;
  logic [7:0]  cpuwdata, dmawdata, memrdata;
  logic [7:0]  cpurdata, dmardata, memwdata;
  logic        cpuack, dmaack, memreq, memwr, owner, busy;
  logic [15:0] memaddr;

  mem_arbiter #(.STARVE(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpureq(cpureq), .cpuwr(cpuwr), .cpuaddr(cpuaddr), .cpuwdata(cpuwdata),
    .cpurdata(cpurdata), .cpuack(cpuack),
    .dmareq(dmareq), .dmawr(dmawr), .dmaaddr(dmaaddr), .dmawdata(dmawdata),
    .dmardata(dmardata), .dmaack(dmaack),
    .memreq(memreq), .memwr(memwr), .memaddr(memaddr), .memwdata(memwdata),
    .memrdata(memrdata), .memack(memack), .owner(owner), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural memory: answers memreq after ack_delay waiting BUSY cycles
  logic [7:0] mem [0:65535];
  int ack_delay = 0;
  int wait_cnt  = 0;
  bit ack_hold  = 0;

  always @(negedge clk) begin
    if (ack_hold) begin
      memack   = 1'b1;
      memrdata = mem[memaddr];
    end else if (memreq) begin
      if (wait_cnt >= ack_delay) begin
        memack   = 1'b1;
        memrdata = mem[memaddr];
        if (memwr) mem[memaddr] = memwdata;
        wait_cnt = 0;
      end else begin
        memack = 1'b0;
        wait_cnt++;
      end
    end else begin
      memack   = 1'b0;
      wait_cnt = 0;
    end
  end

  typedef struct {
    bit          dma;
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          dly;
    logic [7:0]  exp_rd;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  initial begin
    int          cyc, lat, ngr, nack_c, nack_d, first_ack;
    bit          got, seen, stable, other_ack;
    logic [15:0] a0;
    logic [7:0]  w0, rd, other_before;
    logic        wr0, prev_req;
    logic [15:0] gaddr [8];
    logic        gown  [8];
    logic        exp_own [6];

    vecs[0] = '{dma:0, wr:0, addr:16'h1337, wdata:8'h00, dly:2, exp_rd:8'h40};
    vecs[1] = '{dma:1, wr:1, addr:16'h2004, wdata:8'hA5, dly:0, exp_rd:8'h00};
    vecs[2] = '{dma:0, wr:1, addr:16'h0010, wdata:8'h5A, dly:1, exp_rd:8'h00};
    vecs[3] = '{dma:1, wr:0, addr:16'h2004, wdata:8'h00, dly:1, exp_rd:8'hA5};
    vecs[4] = '{dma:0, wr:0, addr:16'h0010, wdata:8'h00, dly:0, exp_rd:8'h5A};
    vecs[5] = '{dma:1, wr:0, addr:16'hFFFF, wdata:8'h00, dly:3, exp_rd:8'hC3};

    for (int i = 0; i < 65536; i++) mem[i] = 8'(i ^ (i >> 8));
    mem[16'h1337] = 8'h40;
    mem[16'h0082] = 8'h90;
    mem[16'h0200] = 8'h3C;
    mem[16'hFFFF] = 8'hC3;

    reset_n = 1'b0;
    cpureq = 0; cpuwr = 0; cpuaddr = '0; cpuwdata = '0;
    dmareq = 0; dmawr = 0; dmaaddr = '0; dmawdata = '0;
    memack = 0; memrdata = '0;

    #3;
    chk("reset_state", {memreq, memwr, cpuack, dmaack, busy, owner, memaddr, memwdata, cpurdata, dmardata}, 0);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);

    // ---------------- table-driven single accesses ----------------
    for (int v = 0; v < NV; v++) begin
      other_before = vecs[v].dma ? cpurdata : dmardata;
      ack_delay = vecs[v].dly;
      if (vecs[v].dma) begin
        dmareq = 1; dmawr = vecs[v].wr; dmaaddr = vecs[v].addr; dmawdata = vecs[v].wdata;
      end else begin
        cpureq = 1; cpuwr = vecs[v].wr; cpuaddr = vecs[v].addr; cpuwdata = vecs[v].wdata;
      end
      cyc = 0; lat = 0; got = 0; seen = 0; stable = 1; other_ack = 0; rd = '0;
      a0 = '0; w0 = '0; wr0 = 0;
      while (!got && cyc < 40) begin
        @(posedge clk); @(negedge clk); cyc++;
        if (memreq && !seen) begin
          seen = 1;
          chk($sformatf("v%0d_memaddr", v), memaddr, vecs[v].addr);
          chk($sformatf("v%0d_memwr", v), memwr, vecs[v].wr);
          if (vecs[v].wr) chk($sformatf("v%0d_memwdata", v), memwdata, vecs[v].wdata);
          chk($sformatf("v%0d_owner", v), owner, vecs[v].dma);
          a0 = memaddr; w0 = memwdata; wr0 = memwr;
        end else if (memreq) begin
          if (memaddr !== a0 || memwdata !== w0 || memwr !== wr0) stable = 0;
        end
        if (vecs[v].dma ? cpuack : dmaack) other_ack = 1;
        if (vecs[v].dma ? dmaack : cpuack) begin
          got = 1; lat = cyc;
          rd = vecs[v].dma ? dmardata : cpurdata;
          dmareq = 0; cpureq = 0;
        end
      end
      chk($sformatf("v%0d_acked", v), got, 1);
      chk($sformatf("v%0d_latency", v), lat, 2 + vecs[v].dly);
      chk($sformatf("v%0d_stable", v), stable, 1);
      chk($sformatf("v%0d_other_ack", v), other_ack, 0);
      if (!vecs[v].wr) chk($sformatf("v%0d_rdata", v), rd, vecs[v].exp_rd);
      chk($sformatf("v%0d_other_rdata", v), vecs[v].dma ? cpurdata : dmardata, other_before);
      @(posedge clk); @(negedge clk);
      chk($sformatf("v%0d_idle", v), {cpuack, dmaack, busy, memreq}, 0);
    end

    // ---------------- simultaneous requests: DMA first ----------------
    ack_delay = 0;
    cpureq = 1; cpuwr = 0; cpuaddr = 16'h0082;
    dmareq = 1; dmawr = 0; dmaaddr = 16'h0200;
    ngr = 0; nack_c = 0; nack_d = 0; first_ack = -1; got = 0; cyc = 0; prev_req = 0;
    while (!got && cyc < 30) begin
      @(posedge clk); @(negedge clk); cyc++;
      if (memreq && !prev_req && ngr < 8) begin gaddr[ngr] = memaddr; gown[ngr] = owner; ngr++; end
      prev_req = memreq;
      if (dmaack) begin nack_d++; dmareq = 0; if (first_ack < 0) first_ack = 1; end
      if (cpuack) begin nack_c++; cpureq = 0; got = 1; if (first_ack < 0) first_ack = 0; end
    end
    chk("sim_done", got, 1);
    chk("sim_grants", ngr, 2);
    chk("sim_g0", {gown[0], gaddr[0]}, {1'b1, 16'h0200});
    chk("sim_g1", {gown[1], gaddr[1]}, {1'b0, 16'h0082});
    chk("sim_first_ack_dma", first_ack, 1);
    chk("sim_ack_counts", {nack_d[7:0], nack_c[7:0]}, {8'd1, 8'd1});
    chk("sim_cpurdata", cpurdata, 8'h90);
    chk("sim_dmardata", dmardata, 8'h3C);
    @(posedge clk); @(negedge clk);

    // ---------------- memack stuck high ----------------
    ack_hold = 1;
    @(negedge clk);
    cpureq = 1; cpuwr = 0; cpuaddr = 16'h1337;
    ngr = 0; nack_c = 0; prev_req = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); @(negedge clk);
      if (memreq && !prev_req) ngr++;
      prev_req = memreq;
      if (cpuack) begin nack_c++; cpureq = 0; end
    end
    chk("hold_grants", ngr, 1);
    chk("hold_acks", nack_c, 1);
    chk("hold_idle", {busy, memreq}, 0);
    chk("hold_cpurdata", cpurdata, 8'h40);
    ack_hold = 0;
    @(negedge clk); @(negedge clk);

    // ---------------- starvation ----------------
`ifdef ARB_STARVE_EN
    exp_own = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`else
    exp_own = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    ack_delay = 0;
    dmareq = 1; dmawr = 0; dmaaddr = 16'h0300;
    cpureq = 1; cpuwr = 0; cpuaddr = 16'h0010;
    ngr = 0; cyc = 0; prev_req = 0;
    while (ngr < 6 && cyc < 60) begin
      @(posedge clk); @(negedge clk); cyc++;
      if (memreq && !prev_req) begin gown[ngr] = owner; gaddr[ngr] = memaddr; ngr++; end
      prev_req = memreq;
      if (cpuack) cpureq = 0;
    end
    dmareq = 0; cpureq = 0;
    chk("starve_grants", ngr, 6);
    for (int g = 0; g < 6; g++)
      chk($sformatf("starve_owner%0d", g), gown[g], exp_own[g]);
    cyc = 0;
    while (busy && cyc < 10) begin @(posedge clk); @(negedge clk); cyc++; end
    chk("starve_drain", busy, 0);
    @(negedge clk);

    // ---------------- async reset mid-transaction ----------------
    ack_delay = 10;
    cpureq = 1; cpuwr = 0; cpuaddr = 16'h1337;
    @(posedge clk); @(negedge clk);
    chk("rst_pre_memreq", {memreq, busy}, 2'b11);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async", {memreq, busy, cpuack, dmaack, owner, memaddr}, 0);
    cpureq = 0;
    @(negedge clk); reset_n = 1'b1;
    nack_c = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); @(negedge clk);
      if (cpuack || dmaack) nack_c++;
    end
    chk("rst_no_ack", nack_c, 0);
    chk("rst_idle", {busy, memreq}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 16-bit-address, 8-bit-data memory port between the CPU and a DMA requester (sprite/OAM DMA).
- Each side has a request/acknowledge handshake. The arbiter sits between the requesters and the memory/bus decoder.
- Fixed priority: DMA wins over CPU. An optional starvation guard bounds how long the CPU can wait.
- Per-port read data and acknowledge are registered.

Parameters:
- STARVE, 4: consecutive DMA grants with CPU pending before the CPU is forced to win. Used only with ARB_STARVE_EN. Legal range 1..15.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cpureq  in  1  CPU access request; held until cpuack
- cpuwr  in  1  1 = write, 0 = read
- cpuaddr  in  16  CPU address
- cpuwdata  in  8  CPU write data
- cpurdata  out  8  CPU read data, valid while cpuack=1
- cpuack  out  1  one-cycle completion pulse to CPU
- dmareq  in  1  DMA access request; held until dmaack
- dmawr  in  1  DMA write strobe
- dmaaddr  in  16  DMA address
- dmawdata  in  8  DMA write data
- dmardata  out  8  DMA read data, valid while dmaack=1
- dmaack  out  1  one-cycle completion pulse to DMA
- memreq  out  1  memory request; held until memack
- memwr  out  1  memory write strobe, qualified by memreq
- memaddr  out  16  memory address
- memwdata  out  8  memory write data
- memrdata  in  8  memory read data, sampled when memack=1
- memack  in  1  memory completion, one-cycle pulse
- owner  out  1  current/last grant: 0 = CPU, 1 = DMA
- busy  out  1  1 when state is not IDLE

Behaviour:
- Reset (asynchronous, reset_n=0) clears: memreq, memwr, cpuack, dmaack, busy, owner; memaddr=0000, memwdata=00, cpurdata=00, dmardata=00; state=IDLE; starvation count=0.
- Reset mid-transaction: memreq drops immediately. No ack is issued for the aborted access.
- Three states: IDLE, BUSY, DONE.
- IDLE:
  - If dmareq=1, grant DMA. Otherwise, if cpureq=1, grant CPU.
  - On grant, at the clock edge: register memaddr/memwr/memwdata from the winner, set memreq=1, set owner, go to BUSY.
  - No request: stay in IDLE, memreq=0.
- BUSY:
  - Hold memreq and all mem* outputs stable until memack=1.
  - On memack: if the access was a read, latch memrdata into the winner's rdata register (the other port's rdata is unchanged). Clear memreq and memwr, raise the winner's ack, go to DONE.
  - A memack arriving in the same cycle memreq first rises is legal and is honoured.
- DONE:
  - The ack is high for exactly this one cycle.
  - Return to IDLE. No grant is made in this cycle, because the requester still holds req.
- Requester rule: deassert req in the cycle after ack. A req still high in IDLE is treated as a new request.
- Latency: grant edge -> memreq=1. Best case, with memack in the first BUSY cycle, ack appears 2 cycles after request is sampled. Back-to-back throughput is one access per 3 cycles.
- Requester inputs are ignored outside IDLE. Changes to a pending requester's addr/data while it waits are allowed; the values at grant time are used.
- memack while IDLE or DONE is ignored.
- Both requests present in IDLE: DMA wins. The CPU keeps waiting with no ack.
- busy = (state != IDLE). owner holds its value through IDLE.

Optional Feature:
- Macro: ARB_STARVE_EN.
- Defined:
  - A 4-bit counter increments at each DMA grant made while cpureq=1, saturating at 15.
  - It clears on any CPU grant and whenever cpureq=0 in IDLE.
  - When count >= STARVE and cpureq=1 in IDLE, the CPU wins even if dmareq=1.
- Undefined: no counter exists and DMA strictly wins.

Test Plan:
- Reset with memreq high in BUSY, reset_n=0 asynchronously -> memreq=0, acks=0, busy=0 in the same cycle with no clock edge needed.
- CPU read 0x1337, memory returns 0x40 with memack after 2 BUSY cycles -> memaddr=1337, memwr=0, cpurdata=40 with one-cycle cpuack, dmaack never high, dmardata unchanged.
- DMA write 0x2004 = 0xA5 with memack in the first BUSY cycle -> memwr=1, memwdata=A5 held until memack; dmaack pulses 2 cycles after the request is sampled; owner=1.
- cpureq and dmareq both rise in the same cycle (CPU read 0x0082, DMA read 0x0200) -> DMA served first, then CPU in the next IDLE; cpurdata = the value at 0x0082 (0x90).
- memack held permanently high, single CPU request -> exactly one cpuack, no second grant in DONE, state returns to IDLE.
- ARB_STARVE_EN defined, STARVE=4, dmareq constantly high with cpureq pending -> 4 DMA grants, then a CPU grant, then DMA resumes. Macro undefined -> the CPU is never granted.
